// File: rtl/div_sqrt_arb_pkg.sv
// -----------------------------------------------------------------------------
// div_sqrt_arb_pkg
// Shared types and constants for the div/sqrt arbiter slice.
//   - arb_state_e : arbiter FSM states (IDLE / BUSY / RESP)
//   - FLAG_*_IDX  : bit positions inside the 3-bit flag vector
//                   {Exp_OF, Exp_UF, Div_zero}
//   - OPERAND_W / RM_W / PREC_W : per-requester field widths
//   - unit_resp_t : result + flags captured from the unit
//   - idx_width() : width of a requester index (at least one bit)
// -----------------------------------------------------------------------------
package div_sqrt_arb_pkg;

  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned RM_W      = 2;
  localparam int unsigned PREC_W    = 5;
  localparam int unsigned FLAGS_W   = 3;

  localparam int unsigned FLAG_DZ_IDX = 0;
  localparam int unsigned FLAG_UF_IDX = 1;
  localparam int unsigned FLAG_OF_IDX = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [OPERAND_W-1:0] result;
    logic [FLAGS_W-1:0]   flags;
  } unit_resp_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_sqrt_arb_sel.sv
// -----------------------------------------------------------------------------
// div_sqrt_arb_sel
// Purely combinational winner selection. The search starts at requester
// index 'ptr' and wraps around; the first asserted request wins. With ptr
// tied to zero this degenerates to fixed lowest-index priority.
// Ports:
//   req        in  NUM_REQ  request vector
//   ptr        in  IDX_W    search start index (must be < NUM_REQ)
//   gnt_onehot out NUM_REQ  one-hot winner (all zero when no request)
//   winner     out IDX_W    binary index of the winner
//   valid      out 1        at least one request is asserted
// -----------------------------------------------------------------------------
module div_sqrt_arb_sel
  import div_sqrt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Walk offsets 0..NUM_REQ-1 from the pointer; the modulo is a single
  // conditional subtract because ptr + offset never reaches 2*NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    gnt_onehot = '0;
    winner     = '0;
    valid      = 1'b0;
    for (int unsigned ofs = 0; ofs < NUM_REQ; ofs++) begin
      idx = 32'(ptr) + ofs;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!valid && req[IDX_W'(idx)]) begin
        valid                     = 1'b1;
        gnt_onehot[IDX_W'(idx)]   = 1'b1;
        winner                    = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/div_sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// div_sqrt_arbiter
// Shares one div/sqrt unit between NUM_REQ requesters with at most one
// operation in flight. A request is granted in IDLE when the unit is ready;
// the grant cycle also carries the start pulse and the winner's operands.
// The unit's result is captured on Unit_done_SI and presented to the owner
// until it accepts with its Res_ready_SI bit.
//
// Configuration macro:
//   DIV_SQRT_ARB_RR_EN  defined   -> round-robin arbitration (pointer moves
//                                    to winner+1 after every grant)
//                       undefined -> fixed priority, lowest index wins
//
// Ports:
//   Clk_CI, Rst_RBI               clock, asynchronous active-low reset
//   Req_SI, Sqrt_SI               per-requester request / op select (1=sqrt)
//   Operand_a_DI, Operand_b_DI    per-requester operands, requester 0 in LSBs
//   RM_SI, Precision_ctl_SI       per-requester rounding mode / precision
//   Gnt_SO                        one-hot, one-cycle grant
//   Valid_SO, Res_ready_SI        one-hot result valid to owner / accept
//   Result_DO, Flags_DO           shared result bus, flags {OF, UF, DZ}
//   Div_start_SO, Sqrt_start_SO   unit start pulses
//   Unit_a_DO, Unit_b_DO,
//   Unit_RM_DO, Unit_prec_DO      operands towards the unit
//   Unit_result_DI, Unit_OF_SI,
//   Unit_UF_SI, Unit_DZ_SI        unit result and flags
//   Unit_ready_SI, Unit_done_SI   unit can accept / result valid
// -----------------------------------------------------------------------------
module div_sqrt_arbiter
  import div_sqrt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                          Clk_CI,
  input  logic                          Rst_RBI,
  input  logic [NUM_REQ-1:0]            Req_SI,
  input  logic [NUM_REQ-1:0]            Sqrt_SI,
  input  logic [NUM_REQ*OPERAND_W-1:0]  Operand_a_DI,
  input  logic [NUM_REQ*OPERAND_W-1:0]  Operand_b_DI,
  input  logic [NUM_REQ*RM_W-1:0]       RM_SI,
  input  logic [NUM_REQ*PREC_W-1:0]     Precision_ctl_SI,
  output logic [NUM_REQ-1:0]            Gnt_SO,
  output logic [NUM_REQ-1:0]            Valid_SO,
  input  logic [NUM_REQ-1:0]            Res_ready_SI,
  output logic [OPERAND_W-1:0]          Result_DO,
  output logic [FLAGS_W-1:0]            Flags_DO,
  output logic                          Div_start_SO,
  output logic                          Sqrt_start_SO,
  output logic [OPERAND_W-1:0]          Unit_a_DO,
  output logic [OPERAND_W-1:0]          Unit_b_DO,
  output logic [RM_W-1:0]               Unit_RM_DO,
  output logic [PREC_W-1:0]             Unit_prec_DO,
  input  logic [OPERAND_W-1:0]          Unit_result_DI,
  input  logic                          Unit_OF_SI,
  input  logic                          Unit_UF_SI,
  input  logic                          Unit_DZ_SI,
  input  logic                          Unit_ready_SI,
  input  logic                          Unit_done_SI
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_e           state_q;
  arb_state_e           state_d;
  logic [IDX_W-1:0]     owner_q;
  unit_resp_t           hold_q;

  logic [NUM_REQ-1:0]   sel_gnt;
  logic [IDX_W-1:0]     sel_winner;
  logic [IDX_W-1:0]     sel_ptr;
  logic                 sel_valid;

  logic                 grant_fire;
  logic                 owner_accept;
  logic [FLAGS_W-1:0]   unit_flags;

  logic [OPERAND_W-1:0] a_arr    [NUM_REQ];
  logic [OPERAND_W-1:0] b_arr    [NUM_REQ];
  logic [RM_W-1:0]      rm_arr   [NUM_REQ];
  logic [PREC_W-1:0]    prec_arr [NUM_REQ];

  // Unpack the flat per-requester buses so the winner can index them.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]    = Operand_a_DI[g*OPERAND_W +: OPERAND_W];
    assign b_arr[g]    = Operand_b_DI[g*OPERAND_W +: OPERAND_W];
    assign rm_arr[g]   = RM_SI[g*RM_W +: RM_W];
    assign prec_arr[g] = Precision_ctl_SI[g*PREC_W +: PREC_W];
  end

  div_sqrt_arb_sel #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_sel (
    .req        (Req_SI),
    .ptr        (sel_ptr),
    .gnt_onehot (sel_gnt),
    .winner     (sel_winner),
    .valid      (sel_valid)
  );

  // The reset term keeps every output quiet while reset is held, even if a
  // request and Unit_ready_SI are already present.
  assign grant_fire   = Rst_RBI && (state_q == ST_IDLE) && Unit_ready_SI && sel_valid;
  assign owner_accept = (state_q == ST_RESP) && Res_ready_SI[owner_q];

`ifdef DIV_SQRT_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;

  // Round-robin pointer: the requester after the last winner gets first look.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      rr_ptr_q <= '0;
    end else if (grant_fire) begin
      rr_ptr_q <= (sel_winner == IDX_W'(NUM_REQ - 1)) ? '0 : sel_winner + IDX_W'(1);
    end
  end

  assign sel_ptr = rr_ptr_q;
`else
  assign sel_ptr = '0;
`endif

  // FSM state register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. Unit_done_SI only matters in BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_fire)   state_d = ST_BUSY;
      ST_BUSY: if (Unit_done_SI) state_d = ST_RESP;
      ST_RESP: if (owner_accept) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    unit_flags              = '0;
    unit_flags[FLAG_OF_IDX] = Unit_OF_SI;
    unit_flags[FLAG_UF_IDX] = Unit_UF_SI;
    unit_flags[FLAG_DZ_IDX] = Unit_DZ_SI;
  end

  // Owner and result hold register; a reset drops any in-flight result.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      owner_q <= '0;
      hold_q  <= '0;
    end else begin
      if (grant_fire) begin
        owner_q <= sel_winner;
      end
      if ((state_q == ST_BUSY) && Unit_done_SI) begin
        hold_q.result <= Unit_result_DI;
        hold_q.flags  <= unit_flags;
      end
    end
  end

  // FSM outputs: grant/start/operands only in the grant cycle, result bus
  // only in RESP, zero everywhere else.
  always_comb begin
    Gnt_SO        = '0;
    Div_start_SO  = 1'b0;
    Sqrt_start_SO = 1'b0;
    Unit_a_DO     = '0;
    Unit_b_DO     = '0;
    Unit_RM_DO    = '0;
    Unit_prec_DO  = '0;
    Valid_SO      = '0;
    Result_DO     = '0;
    Flags_DO      = '0;
    if (grant_fire) begin
      Gnt_SO        = sel_gnt;
      Div_start_SO  = ~Sqrt_SI[sel_winner];
      Sqrt_start_SO = Sqrt_SI[sel_winner];
      Unit_a_DO     = a_arr[sel_winner];
      Unit_b_DO     = b_arr[sel_winner];
      Unit_RM_DO    = rm_arr[sel_winner];
      Unit_prec_DO  = prec_arr[sel_winner];
    end
    if (state_q == ST_RESP) begin
      Valid_SO[owner_q] = 1'b1;
      Result_DO         = hold_q.result;
      Flags_DO          = hold_q.flags;
    end
  end

endmodule

// File: tb/tb_div_sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_sqrt_arbiter
// Self-checking bench for div_sqrt_arbiter with three requesters. The bench
// plays the part of both the requesters and the div/sqrt unit; the expected
// winner comes from a plain arbitration rule (lowest index, or a round-robin
// start index when DIV_SQRT_ARB_RR_EN is defined) applied to the bench's own
// request bookkeeping.
// -----------------------------------------------------------------------------
module tb_div_sqrt_arbiter;

  localparam int N = 3;

  logic            Clk_CI = 1'b0;
  logic            Rst_RBI;
  logic [N-1:0]    Req_SI;
  logic [N-1:0]    Sqrt_SI;
  logic [N*32-1:0] Operand_a_DI;
  logic [N*32-1:0] Operand_b_DI;
  logic [N*2-1:0]  RM_SI;
  logic [N*5-1:0]  Precision_ctl_SI;
  logic [N-1:0]    Gnt_SO;
  logic [N-1:0]    Valid_SO;
  logic [N-1:0]    Res_ready_SI;
  logic [31:0]     Result_DO;
  logic [2:0]      Flags_DO;
  logic            Div_start_SO;
  logic            Sqrt_start_SO;
  logic [31:0]     Unit_a_DO;
  logic [31:0]     Unit_b_DO;
  logic [1:0]      Unit_RM_DO;
  logic [4:0]      Unit_prec_DO;
  logic [31:0]     Unit_result_DI;
  logic            Unit_OF_SI;
  logic            Unit_UF_SI;
  logic            Unit_DZ_SI;
  logic            Unit_ready_SI;
  logic            Unit_done_SI;

  int checks   = 0;
  int failures = 0;

  // Requester-side model state.
  logic [N-1:0] reqM;
  logic [31:0]  aM    [N];
  logic [31:0]  bM    [N];
  logic         sqrtM [N];
  logic [1:0]   rmM   [N];
  logic [4:0]   precM [N];
`ifdef DIV_SQRT_ARB_RR_EN
  int rrStart = 0;
`endif

  div_sqrt_arbiter #(.NUM_REQ(N)) dut (
    .Clk_CI           (Clk_CI),
    .Rst_RBI          (Rst_RBI),
    .Req_SI           (Req_SI),
    .Sqrt_SI          (Sqrt_SI),
    .Operand_a_DI     (Operand_a_DI),
    .Operand_b_DI     (Operand_b_DI),
    .RM_SI            (RM_SI),
    .Precision_ctl_SI (Precision_ctl_SI),
    .Gnt_SO           (Gnt_SO),
    .Valid_SO         (Valid_SO),
    .Res_ready_SI     (Res_ready_SI),
    .Result_DO        (Result_DO),
    .Flags_DO         (Flags_DO),
    .Div_start_SO     (Div_start_SO),
    .Sqrt_start_SO    (Sqrt_start_SO),
    .Unit_a_DO        (Unit_a_DO),
    .Unit_b_DO        (Unit_b_DO),
    .Unit_RM_DO       (Unit_RM_DO),
    .Unit_prec_DO     (Unit_prec_DO),
    .Unit_result_DI   (Unit_result_DI),
    .Unit_OF_SI       (Unit_OF_SI),
    .Unit_UF_SI       (Unit_UF_SI),
    .Unit_DZ_SI       (Unit_DZ_SI),
    .Unit_ready_SI    (Unit_ready_SI),
    .Unit_done_SI     (Unit_done_SI)
  );

  always #5 Clk_CI = ~Clk_CI;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  // Drive the model's requester state onto the DUT and let it settle.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      Operand_a_DI[i*32 +: 32]   = aM[i];
      Operand_b_DI[i*32 +: 32]   = bM[i];
      RM_SI[i*2 +: 2]            = rmM[i];
      Precision_ctl_SI[i*5 +: 5] = precM[i];
      Sqrt_SI[i]                 = sqrtM[i];
    end
    Req_SI = reqM;
    #1;
  endtask

  function automatic int pickWinner(input logic [N-1:0] r);
`ifdef DIV_SQRT_ARB_RR_EN
    for (int k = 0; k < N; k++) begin
      if (r[(rrStart + k) % N]) return (rrStart + k) % N;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"},    Gnt_SO, '0);
    checkOutput({tag, "_valid"},  Valid_SO, '0);
    checkOutput({tag, "_starts"}, {Div_start_SO, Sqrt_start_SO}, '0);
    checkOutput({tag, "_unit"},   {Unit_a_DO, Unit_b_DO}, '0);
    checkOutput({tag, "_ctl"},    {Unit_RM_DO, Unit_prec_DO}, '0);
    checkOutput({tag, "_result"}, {Result_DO, Flags_DO}, '0);
  endtask

  // One complete transaction from the grant cycle to the accept.
  task automatic runOp(input int lat, input logic [31:0] res, input logic [2:0] flg,
                       input int stall, input bit dropReq);
    int w;
    logic [N-1:0] ownerMask;
    w = pickWinner(reqM);
    if (w < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL runop_no_request observed=none expected=request");
      return;
    end
    ownerMask = N'(1) << w;
    checkOutput("gnt", Gnt_SO, ownerMask);
    checkOutput("div_start", Div_start_SO, !sqrtM[w]);
    checkOutput("sqrt_start", Sqrt_start_SO, sqrtM[w]);
    checkOutput("unit_a", Unit_a_DO, aM[w]);
    checkOutput("unit_b", Unit_b_DO, bM[w]);
    checkOutput("unit_rm", Unit_RM_DO, rmM[w]);
    checkOutput("unit_prec", Unit_prec_DO, precM[w]);
`ifdef DIV_SQRT_ARB_RR_EN
    rrStart = (w + 1) % N;
`endif
    tick();
    if (dropReq) reqM[w] = 1'b0;
    applyStimulus();
    checkOutput("busy_gnt", Gnt_SO, '0);
    checkOutput("busy_starts", {Div_start_SO, Sqrt_start_SO}, '0);
    checkOutput("busy_unit_a", Unit_a_DO, '0);
    checkOutput("busy_valid", Valid_SO, '0);
    checkOutput("busy_result", Result_DO, '0);
    for (int k = 1; k < lat; k++) begin
      tick();
      checkOutput("busy_wait_valid", Valid_SO, '0);
    end
    Unit_done_SI   = 1'b1;
    Unit_result_DI = res;
    {Unit_OF_SI, Unit_UF_SI, Unit_DZ_SI} = flg;
    #1;
    checkOutput("done_cycle_valid", Valid_SO, '0);
    tick();
    Unit_done_SI   = 1'b0;
    Unit_result_DI = ~res;
    {Unit_OF_SI, Unit_UF_SI, Unit_DZ_SI} = ~flg;
    #1;
    checkOutput("resp_valid", Valid_SO, ownerMask);
    checkOutput("resp_result", Result_DO, res);
    checkOutput("resp_flags", Flags_DO, flg);
    checkOutput("resp_gnt", Gnt_SO, '0);
    // Non-owner accepts and stray done pulses must both be ignored.
    for (int k = 0; k < stall; k++) begin
      Res_ready_SI = ~ownerMask;
      Unit_done_SI = 1'b1;
      tick();
      checkOutput("stall_valid", Valid_SO, ownerMask);
      checkOutput("stall_result", Result_DO, res);
      checkOutput("stall_flags", Flags_DO, flg);
      checkOutput("stall_gnt", Gnt_SO, '0);
    end
    Unit_done_SI = 1'b0;
    Res_ready_SI = ownerMask;
    #1;
    checkOutput("accept_valid", Valid_SO, ownerMask);
    tick();
    Res_ready_SI = '0;
    #1;
    checkOutput("after_valid", Valid_SO, '0);
    checkOutput("after_result", {Result_DO, Flags_DO}, '0);
  endtask

  initial begin
    Rst_RBI        = 1'b1;
    Unit_ready_SI  = 1'b0;
    Unit_done_SI   = 1'b0;
    Unit_result_DI = '0;
    {Unit_OF_SI, Unit_UF_SI, Unit_DZ_SI} = '0;
    Res_ready_SI   = '0;
    reqM           = '0;
    for (int i = 0; i < N; i++) begin
      aM[i] = '0; bM[i] = '0; sqrtM[i] = 1'b0; rmM[i] = '0; precM[i] = '0;
    end
    applyStimulus();
    #1 Rst_RBI = 1'b0;
    #1;
    checkAllZero("reset");
    tick();
    tick();
    Rst_RBI = 1'b1;
    #1;

    // Unit not ready: request must wait without grant or start.
    aM[0] = 32'h4040_0000; bM[0] = 32'h3F80_0000; sqrtM[0] = 1'b0;
    reqM  = 3'b001;
    applyStimulus();
    for (int k = 0; k < 3; k++) begin
      checkOutput("notready_gnt", Gnt_SO, '0);
      checkOutput("notready_start", {Div_start_SO, Sqrt_start_SO}, '0);
      tick();
    end
    Unit_ready_SI = 1'b1;
    #1;
    // 3.0 / 1.0
    runOp(3, 32'h4040_0000, 3'b000, 0, 1'b1);

    // sqrt(4.0) = 2.0 on requester 1
    aM[1] = 32'h4080_0000; bM[1] = '0; sqrtM[1] = 1'b1; rmM[1] = 2'd1; precM[1] = 5'd23;
    reqM  = 3'b010;
    applyStimulus();
    runOp(2, 32'h4000_0000, 3'b000, 0, 1'b1);

    // 1.0 / 0.0 on requester 2 raises divide-by-zero
    aM[2] = 32'h3F80_0000; bM[2] = '0; sqrtM[2] = 1'b0; rmM[2] = 2'd3; precM[2] = 5'd8;
    reqM  = 3'b100;
    applyStimulus();
    runOp(4, 32'h7F80_0000, 3'b001, 0, 1'b1);

    // Backpressure with a competing request waiting
    reqM = 3'b011;
    applyStimulus();
    runOp(2, 32'hDEAD_BEEF, 3'b110, 10, 1'b1);
    runOp(1, 32'h1234_5678, 3'b010, 0, 1'b1);

    // Contention: both requests held across four operations
    reqM = 3'b011;
    applyStimulus();
    for (int k = 0; k < 4; k++) begin
      runOp(2, $urandom, 3'b000, 0, 1'b0);
    end
    reqM = '0;
    applyStimulus();

    // Reset while BUSY, then a late done pulse
    reqM = 3'b100;
    applyStimulus();
    checkOutput("pre_reset_gnt", Gnt_SO, 3'b100);
    tick();
    reqM = 3'b010;
    applyStimulus();
    Rst_RBI = 1'b0;
    #1;
    checkAllZero("midbusy_reset");
    tick();
    tick();
    checkAllZero("midbusy_reset_held");
`ifdef DIV_SQRT_ARB_RR_EN
    rrStart = 0;
`endif
    reqM = '0;
    applyStimulus();
    Rst_RBI = 1'b1;
    Unit_done_SI   = 1'b1;
    Unit_result_DI = 32'hCAFE_F00D;
    #1;
    tick();
    Unit_done_SI = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("late_done_valid", Valid_SO, '0);
      checkOutput("late_done_result", Result_DO, '0);
      tick();
    end

    // Randomized traffic; held requests keep their operands.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!reqM[i] && ($urandom_range(0, 1) == 1)) begin
          reqM[i]  = 1'b1;
          aM[i]    = $urandom;
          bM[i]    = $urandom;
          sqrtM[i] = 1'($urandom_range(0, 1));
          rmM[i]   = 2'($urandom_range(0, 3));
          precM[i] = 5'($urandom_range(0, 31));
        end
      end
      if (reqM == '0) begin
        reqM[0] = 1'b1;
        aM[0]   = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        Unit_ready_SI = 1'b0;
        applyStimulus();
        checkOutput("rand_notready_gnt", Gnt_SO, '0);
        tick();
        Unit_ready_SI = 1'b1;
      end
      applyStimulus();
      runOp($urandom_range(1, 4), $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_sqrt_arbiter.md
DIV_SQRT_ARBITER -- requirements
Module: div_sqrt_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 2, number of requesters sharing one div/sqrt unit (2..8).
REQ-002 Clk_CI  in  1  clock; one clock, all logic rising-edge.
REQ-003 Rst_RBI  in  1  reset; asynchronous, active-low.
REQ-004 Req_SI  in  NUM_REQ  per-requester operation request, held high until granted.
REQ-005 Sqrt_SI  in  NUM_REQ  per-requester op select: 0 divide, 1 sqrt.
REQ-006 Operand_a_DI, Operand_b_DI  in  NUM_REQ*32  per-requester operands, packed, requester 0 in LSBs.
REQ-007 RM_SI  in  NUM_REQ*2; Precision_ctl_SI  in  NUM_REQ*5  per-requester rounding mode and precision.
REQ-008 Gnt_SO  out  NUM_REQ  one-hot one-cycle grant.
REQ-009 Valid_SO  out  NUM_REQ  one-hot result valid to owner; Res_ready_SI  in  NUM_REQ  owner accepts.
REQ-010 Result_DO  out  32; Flags_DO  out  3 {Exp_OF, Exp_UF, Div_zero}; shared result bus.
REQ-011 Unit side out: Div_start_SO 1, Sqrt_start_SO 1, Unit_a_DO 32, Unit_b_DO 32, Unit_RM_DO 2, Unit_prec_DO 5.
REQ-012 Unit side in: Unit_result_DI 32, Unit_OF_SI, Unit_UF_SI, Unit_DZ_SI, Unit_ready_SI, Unit_done_SI (1 each).

Function
REQ-013 FSM states IDLE, BUSY, RESP; at most one operation in flight.
REQ-014 IDLE: if Unit_ready_SI=1 and any Req_SI bit set, select winner w combinationally; same cycle assert Gnt_SO[w], Div_start_SO=~Sqrt_SI[w] or Sqrt_start_SO=Sqrt_SI[w], drive Unit_* from requester w; latch owner=w; next state BUSY.
REQ-015 Unit_ready_SI=0 in IDLE: no grant, no start, remain IDLE.
REQ-016 Start pulses and Gnt_SO are exactly one cycle and only in IDLE; zero otherwise.
REQ-017 Unit_* operand outputs are zero when no start is asserted.
REQ-018 BUSY: on Unit_done_SI=1 register Unit_result_DI and flags into hold register; next state RESP.
REQ-019 RESP: Valid_SO[owner]=1, Result_DO/Flags_DO from hold register, stable until Res_ready_SI[owner]=1; on accept go IDLE (next grant earliest the following cycle).
REQ-020 Result_DO/Flags_DO are zero outside RESP.
REQ-021 Unit_done_SI in IDLE or RESP is ignored; Res_ready_SI bits of non-owners ignored.
REQ-022 Requests arriving during BUSY/RESP wait; none lost while held.
REQ-023 Latency: grant-to-Valid = unit latency + 1 cycle.

Reset
REQ-024 Asynchronous reset in any state: FSM to IDLE, owner 0, hold register 0, RR pointer 0, all outputs 0; in-flight unit result discarded.

Configuration
REQ-025 DIV_SQRT_ARB_RR_EN defined: round-robin; search starts at pointer, pointer set to w+1 (mod NUM_REQ) on each grant.
REQ-026 DIV_SQRT_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register.

Structure
REQ-027 Package div_sqrt_arb_pkg: state enum, flag-index constants, operand/RM/precision widths (32, 2, 5).
REQ-028 One sub-module div_sqrt_arb_sel: request vector + pointer -> one-hot winner, pure combinational.

Verification
REQ-029 Single div: Req_SI=01, a=0x40400000, b=0x3F800000, RM 0 -> Gnt 01, Div_start 1 cycle, Valid_SO=01, Result 0x40400000, Flags 000.
REQ-030 Contention, RR on: Req_SI=11 held for 4 ops -> grants 0,1,0,1; RR off -> grants 0,0,0,0 while req0 held.
REQ-031 Backpressure: Res_ready_SI low 10 cycles in RESP -> Valid/Result stable, no new Gnt; accept -> IDLE next cycle.
REQ-032 Sqrt and flags: sqrt of 0x40800000 -> Sqrt_start only, Result 0x40000000; divide 1.0/0.0 -> Flags 001.
REQ-033 Reset mid-BUSY: Rst_RBI low 2 cycles -> all outputs 0, state IDLE; subsequent late Unit_done_SI produces no Valid.
REQ-034 Unit_ready_SI=0 with Req_SI=01 -> no Gnt/start until Unit_ready_SI rises.
